// File: rtl/gpio_irq_ctrl.sv
// GPIO block with synchronized inputs, edge-triggered interrupt status and an MSI-style
// request/acknowledge handshake toward the PCIe endpoint.
module gpio_irq_ctrl #(
   parameter int unsigned N_GPIO      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLDOFF     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_GPIO-1:0] gpio_in,
   output logic [N_GPIO-1:0] gpio_out,
   input  logic              reg_wr,
   input  logic              reg_rd,
   input  logic [2:0]        reg_addr,
   input  logic [31:0]       reg_wdata,
   output logic [31:0]       reg_rdata,
   output logic              reg_rvalid,
   input  logic              msi_enable,
   output logic              cfg_interrupt_n,
   input  logic              cfg_interrupt_rdy_n
);

   localparam logic [2:0] AddrDataIn  = 3'd0;
   localparam logic [2:0] AddrDataOut = 3'd1;
   localparam logic [2:0] AddrMask    = 3'd2;
   localparam logic [2:0] AddrRiseEn  = 3'd3;
   localparam logic [2:0] AddrFallEn  = 3'd4;
   localparam logic [2:0] AddrStatus  = 3'd5;
   localparam logic [2:0] AddrCount   = 3'd6;

   localparam logic [2:0] StartupDone = 3'(SYNC_STAGES + 1);
   localparam logic [7:0] HoldLoad    = 8'(HOLDOFF - 1);

   typedef enum logic [1:0] {StIdle, StReq, StHold} irq_state_e;

   logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
   logic [N_GPIO-1:0] sync_d [SYNC_STAGES];
   logic [N_GPIO-1:0] prev_q, prev_d;
   logic [2:0]        startup_q, startup_d;
   logic [N_GPIO-1:0] data_out_q, data_out_d;
   logic [N_GPIO-1:0] mask_q, mask_d;
   logic [N_GPIO-1:0] rise_en_q, rise_en_d;
   logic [N_GPIO-1:0] fall_en_q, fall_en_d;
   logic [N_GPIO-1:0] status_q, status_d;
   logic [31:0]       count_q, count_d;
   logic              armed_q, armed_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   irq_state_e        state_q;
   logic              irq_n_q;
   logic [7:0]        hold_cnt_q;

   logic [N_GPIO-1:0] sync_out, rise, fall, status_set, wdata_g;
   logic              edge_en, ack, fire;
   logic              unused_wdata;

   assign wdata_g      = reg_wdata[N_GPIO-1:0];
   assign unused_wdata = ^reg_wdata;

   assign sync_out   = sync_q[SYNC_STAGES-1];
   assign edge_en    = (startup_q == StartupDone);
   assign rise       = sync_out & ~prev_q;
   assign fall       = ~sync_out & prev_q;
   // Edges are ignored until the chain and prev register hold real pin values.
   assign status_set = edge_en ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
   assign ack        = (state_q == StReq) && !cfg_interrupt_rdy_n;
   assign fire       = (state_q == StIdle) && armed_q && msi_enable;

   always_comb begin
      sync_d[0] = gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      prev_d     = sync_out;
      startup_d  = edge_en ? startup_q : startup_q + 3'd1;
      data_out_d = data_out_q;
      mask_d     = mask_q;
      rise_en_d  = rise_en_q;
      fall_en_d  = fall_en_q;
      status_d   = status_q | status_set;
      if (reg_wr) begin
         unique case (reg_addr)
            AddrDataOut: data_out_d = wdata_g;
            AddrMask:    mask_d     = wdata_g;
            AddrRiseEn:  rise_en_d  = wdata_g;
            AddrFallEn:  fall_en_d  = wdata_g;
            // A new edge in the same cycle as the clear keeps its bit set.
            AddrStatus:  status_d   = (status_q & ~wdata_g) | status_set;
            default: ;
         endcase
      end
      armed_d = (armed_q & ~fire) | (|(status_set & mask_q));
      count_d = ack ? count_q + 32'd1 : count_q;
   end

   always_comb begin
      rvalid_d = reg_rd;
      rdata_d  = rdata_q;
      if (reg_rd) begin
         unique case (reg_addr)
            AddrDataIn:  rdata_d = 32'(sync_out);
            AddrDataOut: rdata_d = 32'(data_out_q);
            AddrMask:    rdata_d = 32'(mask_q);
            AddrRiseEn:  rdata_d = 32'(rise_en_q);
            AddrFallEn:  rdata_d = 32'(fall_en_q);
            AddrStatus:  rdata_d = 32'(status_q);
            AddrCount:   rdata_d = count_q;
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '{default: '0};
         prev_q     <= '0;
         startup_q  <= '0;
         data_out_q <= '0;
         mask_q     <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         status_q   <= '0;
         count_q    <= '0;
         armed_q    <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         startup_q  <= startup_d;
         data_out_q <= data_out_d;
         mask_q     <= mask_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         status_q   <= status_d;
         count_q    <= count_d;
         armed_q    <= armed_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
      end
   end

   // Request stays up until acknowledged even if msi_enable drops meanwhile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         irq_n_q    <= 1'b1;
         hold_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fire) begin
                  state_q <= StReq;
                  irq_n_q <= 1'b0;
               end
            end
            StReq: begin
               if (ack) begin
                  state_q    <= StHold;
                  irq_n_q    <= 1'b1;
                  hold_cnt_q <= HoldLoad;
               end
            end
            StHold: begin
               if (hold_cnt_q == 8'd0) begin
                  state_q <= StIdle;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               irq_n_q <= 1'b1;
            end
         endcase
      end
   end

   assign gpio_out        = data_out_q;
   assign reg_rdata       = rdata_q;
   assign reg_rvalid      = rvalid_q;
   assign cfg_interrupt_n = irq_n_q;

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 SHALL have parameter N_GPIO, default 8, giving the GPIO channel count (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the input synchronizer depth (2..4).
REQ-003 SHALL have parameter HOLDOFF, default 16, giving the minimum idle cycles after an interrupt acknowledge (1..255).
REQ-004 Port clk, input, 1: single clock (trn_clk domain, 62.5 MHz); one clock, all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port gpio_in, input, N_GPIO: asynchronous pin inputs.
REQ-007 Port gpio_out, output, N_GPIO: registered pin outputs.
REQ-008 Port reg_wr, input, 1: register write strobe, one cycle per write.
REQ-009 Port reg_rd, input, 1: register read strobe.
REQ-010 Port reg_addr, input, 3: DWORD register index.
REQ-011 Port reg_wdata, input, 32: write data, already byte-swapped to host order.
REQ-012 Port reg_rdata, output, 32: read data.
REQ-013 Port reg_rvalid, output, 1: read data valid pulse.
REQ-014 Port msi_enable, input, 1: MSI enable from the endpoint config space.
REQ-015 Port cfg_interrupt_n, output, 1: active-low interrupt request to the endpoint.
REQ-016 Port cfg_interrupt_rdy_n, input, 1: active-low interrupt acknowledge from the endpoint.

Function
REQ-017 Register map SHALL be: 0 DATA_IN (RO, synchronized inputs); 1 DATA_OUT (RW, drives gpio_out); 2 IRQ_MASK (RW, 1 = enabled); 3 RISE_EN (RW); 4 FALL_EN (RW); 5 IRQ_STATUS (RW1C); 6 IRQ_COUNT (RO, 32-bit); 7 reads 0 and ignores writes.
REQ-018 Bits above N_GPIO SHALL read 0 and ignore writes.
REQ-019 Reads SHALL have a latency of 1: reg_rdata and reg_rvalid are valid for exactly the cycle after reg_rd. reg_rdata SHALL hold its last value otherwise.
REQ-020 Writes SHALL take effect on the cycle after reg_wr.
REQ-021 Each gpio_in bit SHALL pass through a SYNC_STAGES flop chain, then a one-flop previous-value register.
REQ-022 Rise SHALL be defined as sync & ~prev; fall as ~sync & prev.
REQ-023 Edge detection SHALL be suppressed for the first SYNC_STAGES+1 cycles after rst deasserts.
REQ-024 IRQ_STATUS[i] SHALL set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]). Status sets irrespective of IRQ_MASK.
REQ-025 Pin-to-status latency SHALL be SYNC_STAGES+1 cycles.
REQ-026 A status write SHALL clear each bit written as 1. If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-027 An armed flag SHALL set on any cycle in which a bit of (new status set & IRQ_MASK) is 1.
REQ-028 The interrupt FSM SHALL have three states, IDLE, REQ and HOLD:
- IDLE -> REQ when armed & msi_enable; the armed flag clears on that transition.
- REQ drives cfg_interrupt_n = 0.
- REQ -> HOLD on the cycle cfg_interrupt_rdy_n = 0.
- HOLD counts HOLDOFF cycles, then -> IDLE.
REQ-029 If msi_enable drops while in REQ, the FSM SHALL remain in REQ until acknowledged (endpoint protocol).
REQ-030 Events occurring in REQ or HOLD SHALL set the armed flag and fire after HOLD completes. Multiple events SHALL coalesce into one request.
REQ-031 IRQ_COUNT SHALL increment on each acknowledge and wrap from FFFFFFFF to 0.
REQ-032 cfg_interrupt_n SHALL be registered (glitch-free).

Reset
REQ-033 On rst, all registers SHALL clear to 0: DATA_OUT, IRQ_MASK, RISE_EN, FALL_EN, IRQ_STATUS, IRQ_COUNT, armed flag, synchronizers, reg_rdata; reg_rvalid = 0; FSM = IDLE; cfg_interrupt_n = 1.
REQ-034 Reset asserted mid-REQ SHALL release the request immediately (asynchronously).

Verification
REQ-035 Write DATA_OUT = 0x5A, read addr 1 -> gpio_out = 0x5A one cycle after the write; reg_rdata = 0x0000005A with reg_rvalid one cycle after reg_rd.
REQ-036 MASK = 0x01, RISE_EN = 0x01, msi_enable = 1; gpio_in[0] 0->1 -> STATUS = 0x01 three cycles later; cfg_interrupt_n low the next cycle; hold rdy_n high for 5 cycles, then pulse low -> cfg_interrupt_n high, IRQ_COUNT = 1.
REQ-037 FALL_EN = 0x80, MASK = 0; gpio_in[7] 1->0 -> STATUS = 0x80 and no request. Then write MASK = 0x80 -> still no request (no new event).
REQ-038 Two edges during HOLD -> exactly one further request after HOLDOFF cycles; IRQ_COUNT = 2.
REQ-039 W1C 0x01 to STATUS in the same cycle as a new bit-0 edge -> STATUS bit 0 remains 1.
REQ-040 Assert rst while in REQ -> cfg_interrupt_n = 1 immediately; all registers read 0 after release.
